// File: rtl/div_sequencer.sv
// Iterative RV32M divide controller: 32-step radix-2 restoring division that
// stalls the pipeline while it runs and presents the result for one cycle.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            start_ok;
    logic            signed_op, rem_op, a_neg, b_neg;
    logic            b_zero, overflow;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] step_rem, step_quot, fix_rem, fix_quot;

    always_comb begin
        start_ok  = start_i & funct3_i[2] & ~flush_i;
        signed_op = ~funct3_i[0];
        rem_op    = funct3_i[1];
        a_neg     = signed_op & op_a_i[XLEN-1];
        b_neg     = signed_op & op_b_i[XLEN-1];
        // Negating the most negative value wraps to itself, which is the right
        // unsigned magnitude for the division datapath.
        abs_a     = a_neg ? -op_a_i : op_a_i;
        abs_b     = b_neg ? -op_b_i : op_b_i;
        b_zero    = (op_b_i == '0);
        overflow  = signed_op & (op_a_i == MIN_NEG) & (op_b_i == '1);

        // 33-bit trial subtraction: bit XLEN set means the partial remainder went negative.
        shifted   = {rem_q, quot_q[XLEN-1]};
        diff      = shifted - {1'b0, dvsr_q};
        step_rem  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        step_quot = {quot_q[XLEN-2:0], ~diff[XLEN]};
        fix_quot  = neg_quot_q ? -step_quot : step_quot;
        fix_rem   = neg_rem_q ? -step_rem : step_rem;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (b_zero) begin
                        result_d = rem_op ? op_a_i : '1;
                        state_d  = S_DONE;
                    end else if (overflow) begin
                        result_d = rem_op ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d      = 5'(XLEN - 1);
                        rem_d      = '0;
                        quot_d     = abs_a;
                        dvsr_d     = abs_b;
                        is_rem_d   = rem_op;
                        neg_quot_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        state_d    = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    if (cnt_q == 5'd0) begin
                        result_d = is_rem_q ? fix_rem : fix_quot;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    // Stall is gated by reset so a start sitting on the inputs cannot hold the pipe during reset.
    assign stall_o  = reset & (((state_q == S_IDLE) & start_ok) | (state_q == S_BUSY));
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE) & ~flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: table of divide vectors plus
// hand-written flush, reset and back-to-back sequences.
module tb_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    div_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies a start in the current (cycle 0) window and checks the combinational stall.
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_stall);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        #1;
        check({name, " stall@0"}, 32'(stall_o), 32'(exp_stall));
    endtask

    // Called in cycle 0 after issue(); runs until done_o (bounded) and checks the DONE cycle.
    task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_res,
                             input logic keep_start);
        int cyc;
        logic stall_ok;
        step();
        start_i  = 1'b0;
        #1;
        cyc      = 1;
        stall_ok = 1'b1;
        while (!done_o && cyc < 45) begin
            if (!stall_o || !busy_o) stall_ok = 1'b0;
            step();
            #1;
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " result"}, result_o, exp_res);
        check({name, " stall_hi_busy"}, 32'(stall_ok), 32'd1);
        check({name, " stall@done"}, 32'(stall_o), 32'd0);
        check({name, " busy@done"}, 32'(busy_o), 32'd1);
        start_i = keep_start;
    endtask

    initial begin
        vecs[0]  = '{"divu_100_7",   F_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"remu_100_7",   F_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"div_m7_2",     F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{"rem_m7_2",     F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{"div_5_0",      F_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{"remu_5_0",     F_REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[6]  = '{"div_ovf",      F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{"rem_ovf",      F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{"divu_max_1",   F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[9]  = '{"div_7_m2",     F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[10] = '{"rem_7_m2",     F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[11] = '{"divu_big",     F_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
        vecs[12] = '{"remu_big",     F_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
        vecs[13] = '{"div_min_1",    F_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  33};
        vecs[14] = '{"div_min_2",    F_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
        vecs[15] = '{"remu_0_0",     F_REMU, 32'd0,          32'd0,          32'd0,          1};

        reset    = 1'b0;
        start_i  = 1'b0;
        funct3_i = 3'b000;
        op_a_i   = '0;
        op_b_i   = '0;
        flush_i  = 1'b0;
        #12;
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset stall", 32'(stall_o), 32'd0);
        check("reset result", result_o, 32'd0);
        #10;
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, 1'b1);
            wait_done(vecs[i].name, vecs[i].lat, vecs[i].res, 1'b0);
            step();
            check({vecs[i].name, " busy_after"}, 32'(busy_o), 32'd0);
            check({vecs[i].name, " done_after"}, 32'(done_o), 32'd0);
            check({vecs[i].name, " result_hold"}, result_o, vecs[i].res);
        end

        // funct3[2]=0 start is not a divide.
        issue("ignored_f3", 3'b000, 32'd9, 32'd3, 1'b0);
        step();
        start_i = 1'b0;
        check("ignored_f3 busy", 32'(busy_o), 32'd0);

        // Flush in IDLE suppresses start.
        flush_i = 1'b1;
        issue("idle_flush", F_DIVU, 32'd9, 32'd3, 1'b0);
        step();
        start_i = 1'b0;
        flush_i = 1'b0;
        check("idle_flush busy", 32'(busy_o), 32'd0);

        // Flush at cycle 10, new DIVU 9/3 at cycle 11 finishing at cycle 44.
        begin
            logic early_done;
            early_done = 1'b0;
            issue("flush10", F_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1);
            for (int c = 1; c <= 10; c++) begin
                step();
                start_i = 1'b0;
                if (done_o) early_done = 1'b1;
            end
            flush_i = 1'b1;
            #1;
            check("flush10 done_forced", 32'(done_o), 32'd0);
            step();
            flush_i = 1'b0;
            #1;
            check("flush10 no_done", 32'(early_done | done_o), 32'd0);
            check("flush10 busy@11", 32'(busy_o), 32'd0);
            check("flush10 stall@11", 32'(stall_o), 32'd0);
            issue("after_flush", F_DIVU, 32'd9, 32'd3, 1'b1);
            wait_done("after_flush", 33, 32'd3, 1'b0);
            step();
        end

        // Back-to-back: start held through DONE is ignored there, accepted in the next IDLE.
        issue("b2b_first", F_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done("b2b_first", 33, 32'd14, 1'b1);
        funct3_i = F_DIVU;
        op_a_i   = 32'd9;
        op_b_i   = 32'd3;
        step();
        check("b2b idle busy", 32'(busy_o), 32'd0);
        check("b2b idle stall", 32'(stall_o), 32'd1);
        wait_done("b2b_second", 33, 32'd3, 1'b0);
        step();

        // Flush on the final BUSY step wins: no DONE, result holds.
        begin
            logic any_done;
            any_done = 1'b0;
            issue("flush_last", F_DIVU, 32'd100, 32'd7, 1'b1);
            for (int c = 1; c <= 32; c++) begin
                step();
                start_i = 1'b0;
                if (done_o) any_done = 1'b1;
            end
            check("flush_last busy@32", 32'(busy_o), 32'd1);
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (done_o) any_done = 1'b1;
                step();
            end
            check("flush_last no_done", 32'(any_done), 32'd0);
            check("flush_last busy", 32'(busy_o), 32'd0);
            check("flush_last result_hold", result_o, 32'd3);
        end

        // Reset mid-operation at cycle 20, with a valid start left on the inputs.
        issue("rst_mid", F_DIVU, 32'd50, 32'd5, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            step();
            start_i = 1'b0;
        end
        reset   = 1'b0;
        start_i = 1'b1;
        #1;
        check("rst_mid busy", 32'(busy_o), 32'd0);
        check("rst_mid done", 32'(done_o), 32'd0);
        check("rst_mid stall", 32'(stall_o), 32'd0);
        check("rst_mid result", result_o, 32'd0);
        start_i = 1'b0;
        #3;
        reset = 1'b1;
        step();
        check("rst_rel result", result_o, 32'd0);
        check("rst_rel done", 32'(done_o), 32'd0);
        issue("after_rst", F_DIVU, 32'd50, 32'd5, 1'b1);
        wait_done("after_rst", 33, 32'd10, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
